// File: rtl/driver.sv
`default_nettype none
// ============================================================================
// Module   : driver
// Brief    : Brute-force MD5 preimage search over 8-char lowercase hex strings
// Revision : 1.0
// ============================================================================
module driver #(
    // First candidate hashed after an enable rise; nonzero only to reach the
    // top of the candidate space quickly.
    parameter logic [31:0] START_CANDIDATE = 32'h0000_0000
) (
    input  logic         CLK,
    input  logic         CPU_RESETN,
    input  logic         enable_switch,
    input  logic [127:0] target_selected,
    output logic [31:0]  target,
    output logic         status_paused,
    output logic         status_running,
    output logic         status_warming,
    output logic         status_found,
    output logic         status_done,
    output logic         enabled
);

    localparam logic [2:0] ST_PAUSED  = 3'd0;
    localparam logic [2:0] ST_WARMING = 3'd1;
    localparam logic [2:0] ST_RUNNING = 3'd2;
    localparam logic [2:0] ST_FOUND   = 3'd3;
    localparam logic [2:0] ST_DONE    = 3'd4;

    localparam logic [31:0] IV_A = 32'h6745_2301;
    localparam logic [31:0] IV_B = 32'hefcd_ab89;
    localparam logic [31:0] IV_C = 32'h98ba_dcfe;
    localparam logic [31:0] IV_D = 32'h1032_5476;

    localparam logic [6:0] STEP_LOAD  = 7'd0;
    localparam logic [6:0] STEP_FINAL = 7'd65;

    function automatic logic [31:0] k_const(input logic [5:0] i);
        case (i)
            6'd0:  k_const = 32'hd76aa478; 6'd1:  k_const = 32'he8c7b756;
            6'd2:  k_const = 32'h242070db; 6'd3:  k_const = 32'hc1bdceee;
            6'd4:  k_const = 32'hf57c0faf; 6'd5:  k_const = 32'h4787c62a;
            6'd6:  k_const = 32'ha8304613; 6'd7:  k_const = 32'hfd469501;
            6'd8:  k_const = 32'h698098d8; 6'd9:  k_const = 32'h8b44f7af;
            6'd10: k_const = 32'hffff5bb1; 6'd11: k_const = 32'h895cd7be;
            6'd12: k_const = 32'h6b901122; 6'd13: k_const = 32'hfd987193;
            6'd14: k_const = 32'ha679438e; 6'd15: k_const = 32'h49b40821;
            6'd16: k_const = 32'hf61e2562; 6'd17: k_const = 32'hc040b340;
            6'd18: k_const = 32'h265e5a51; 6'd19: k_const = 32'he9b6c7aa;
            6'd20: k_const = 32'hd62f105d; 6'd21: k_const = 32'h02441453;
            6'd22: k_const = 32'hd8a1e681; 6'd23: k_const = 32'he7d3fbc8;
            6'd24: k_const = 32'h21e1cde6; 6'd25: k_const = 32'hc33707d6;
            6'd26: k_const = 32'hf4d50d87; 6'd27: k_const = 32'h455a14ed;
            6'd28: k_const = 32'ha9e3e905; 6'd29: k_const = 32'hfcefa3f8;
            6'd30: k_const = 32'h676f02d9; 6'd31: k_const = 32'h8d2a4c8a;
            6'd32: k_const = 32'hfffa3942; 6'd33: k_const = 32'h8771f681;
            6'd34: k_const = 32'h6d9d6122; 6'd35: k_const = 32'hfde5380c;
            6'd36: k_const = 32'ha4beea44; 6'd37: k_const = 32'h4bdecfa9;
            6'd38: k_const = 32'hf6bb4b60; 6'd39: k_const = 32'hbebfbc70;
            6'd40: k_const = 32'h289b7ec6; 6'd41: k_const = 32'heaa127fa;
            6'd42: k_const = 32'hd4ef3085; 6'd43: k_const = 32'h04881d05;
            6'd44: k_const = 32'hd9d4d039; 6'd45: k_const = 32'he6db99e5;
            6'd46: k_const = 32'h1fa27cf8; 6'd47: k_const = 32'hc4ac5665;
            6'd48: k_const = 32'hf4292244; 6'd49: k_const = 32'h432aff97;
            6'd50: k_const = 32'hab9423a7; 6'd51: k_const = 32'hfc93a039;
            6'd52: k_const = 32'h655b59c3; 6'd53: k_const = 32'h8f0ccc92;
            6'd54: k_const = 32'hffeff47d; 6'd55: k_const = 32'h85845dd1;
            6'd56: k_const = 32'h6fa87e4f; 6'd57: k_const = 32'hfe2ce6e0;
            6'd58: k_const = 32'ha3014314; 6'd59: k_const = 32'h4e0811a1;
            6'd60: k_const = 32'hf7537e82; 6'd61: k_const = 32'hbd3af235;
            6'd62: k_const = 32'h2ad7d2bb; default: k_const = 32'heb86d391;
        endcase
    endfunction

    function automatic logic [4:0] s_amt(input logic [5:0] i);
        case ({i[5:4], i[1:0]})
            4'h0: s_amt = 5'd7;  4'h1: s_amt = 5'd12; 4'h2: s_amt = 5'd17; 4'h3: s_amt = 5'd22;
            4'h4: s_amt = 5'd5;  4'h5: s_amt = 5'd9;  4'h6: s_amt = 5'd14; 4'h7: s_amt = 5'd20;
            4'h8: s_amt = 5'd4;  4'h9: s_amt = 5'd11; 4'ha: s_amt = 5'd16; 4'hb: s_amt = 5'd23;
            4'hc: s_amt = 5'd6;  4'hd: s_amt = 5'd10; 4'he: s_amt = 5'd15; default: s_amt = 5'd21;
        endcase
    endfunction

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        hex_ascii = (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
    endfunction

    // Padded message block: bytes 0-7 are the hex text, little-endian words.
    function automatic logic [31:0] msg_word(input logic [3:0] g, input logic [31:0] c);
        case (g)
            4'd0:    msg_word = {hex_ascii(c[19:16]), hex_ascii(c[23:20]),
                                 hex_ascii(c[27:24]), hex_ascii(c[31:28])};
            4'd1:    msg_word = {hex_ascii(c[3:0]),   hex_ascii(c[7:4]),
                                 hex_ascii(c[11:8]),  hex_ascii(c[15:12])};
            4'd2:    msg_word = 32'h0000_0080;
            4'd14:   msg_word = 32'h0000_0040;
            default: msg_word = 32'h0000_0000;
        endcase
    endfunction

    function automatic logic [31:0] bswap(input logic [31:0] v);
        bswap = {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    logic         sync1_q, sync2_q, en_prev_q;
    logic [2:0]   state_q, state_d;
    logic [31:0]  cand_q, cand_d;
    logic [127:0] tgt_q, tgt_d;
    logic [31:0]  a_q, b_q, c_q, d_q;
    logic [31:0]  a_d, b_d, c_d, d_d;
    logic [6:0]   step_q, step_d;

    logic [5:0]   w_round;
    logic [3:0]   w_g;
    logic [31:0]  w_f, w_sum, w_rot, w_new_b;
    logic [4:0]   w_s;
    logic         w_rise, w_match;

    assign w_rise  = sync2_q & ~en_prev_q;
    assign w_round = step_q[5:0] - 6'd1;
    assign w_s     = s_amt(w_round);

    always_comb begin
        w_f = 32'h0;
        w_g = 4'h0;
        case (w_round[5:4])
            2'd0: begin w_f = (b_q & c_q) | (~b_q & d_q); w_g = w_round[3:0]; end
            2'd1: begin w_f = (d_q & b_q) | (~d_q & c_q); w_g = w_round[3:0] * 4'd5 + 4'd1; end
            2'd2: begin w_f = b_q ^ c_q ^ d_q;            w_g = w_round[3:0] * 4'd3 + 4'd5; end
            default: begin w_f = c_q ^ (b_q | ~d_q);      w_g = w_round[3:0] * 4'd7; end
        endcase
    end

    assign w_sum   = a_q + w_f + k_const(w_round) + msg_word(w_g, cand_q);
    assign w_rot   = (w_sum << w_s) | (w_sum >> (6'd32 - {1'b0, w_s}));
    assign w_new_b = b_q + w_rot;
    assign w_match = ({bswap(a_q + IV_A), bswap(b_q + IV_B),
                       bswap(c_q + IV_C), bswap(d_q + IV_D)} == tgt_q);

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        tgt_d   = tgt_q;
        a_d     = a_q;
        b_d     = b_q;
        c_d     = c_q;
        d_d     = d_q;
        step_d  = step_q;
        // A low enable overrides every other decision, including a pending rise.
        if (!sync2_q) begin
            state_d = ST_PAUSED;
        end else begin
            case (state_q)
                ST_PAUSED: begin
                    if (w_rise) begin
                        state_d = ST_WARMING;
                        tgt_d   = target_selected;
                        cand_d  = START_CANDIDATE;
                        step_d  = STEP_LOAD;
                    end
                end
                ST_WARMING, ST_RUNNING: begin
                    if (step_q == STEP_LOAD) begin
                        a_d    = IV_A;
                        b_d    = IV_B;
                        c_d    = IV_C;
                        d_d    = IV_D;
                        step_d = 7'd1;
                    end else if (step_q != STEP_FINAL) begin
                        a_d    = d_q;
                        b_d    = w_new_b;
                        c_d    = b_q;
                        d_d    = c_q;
                        step_d = step_q + 7'd1;
                    end else if (w_match) begin
                        state_d = ST_FOUND;
                    end else if (cand_q == 32'hFFFF_FFFF) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUNNING;
                        cand_d  = cand_q + 32'd1;
                        step_d  = STEP_LOAD;
                    end
                end
                ST_FOUND, ST_DONE: ;
                default: state_d = ST_PAUSED;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge CPU_RESETN) begin
        if (CPU_RESETN) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            en_prev_q <= 1'b0;
            state_q   <= ST_PAUSED;
            cand_q    <= 32'h0;
            tgt_q     <= 128'h0;
            a_q       <= 32'h0;
            b_q       <= 32'h0;
            c_q       <= 32'h0;
            d_q       <= 32'h0;
            step_q    <= 7'h0;
        end else begin
            sync1_q   <= enable_switch;
            sync2_q   <= sync1_q;
            en_prev_q <= sync2_q;
            state_q   <= state_d;
            cand_q    <= cand_d;
            tgt_q     <= tgt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            c_q       <= c_d;
            d_q       <= d_d;
            step_q    <= step_d;
        end
    end

    assign target         = cand_q;
    assign enabled        = sync2_q;
    assign status_paused  = (state_q == ST_PAUSED);
    assign status_warming = (state_q == ST_WARMING);
    assign status_running = (state_q == ST_RUNNING);
    assign status_found   = (state_q == ST_FOUND);
    assign status_done    = (state_q == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_driver
// Brief    : Scoreboard bench for driver: expected status events are queued by
//            the stimulus and popped by a monitor on every status change.
// Revision : 1.0
// ============================================================================
module tb_driver;

    localparam logic [4:0] S_PAUSED  = 5'b10000;
    localparam logic [4:0] S_WARMING = 5'b01000;
    localparam logic [4:0] S_RUNNING = 5'b00100;
    localparam logic [4:0] S_FOUND   = 5'b00010;
    localparam logic [4:0] S_DONE    = 5'b00001;
    localparam logic [127:0] H0 = 128'hdd4b21e9ef71e1291183a46b913ae6f2;

    localparam logic [31:0] KT [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a,
        32'ha8304613, 32'hfd469501, 32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821, 32'hf61e2562, 32'hc040b340,
        32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8,
        32'h676f02d9, 32'h8d2a4c8a, 32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70, 32'h289b7ec6, 32'heaa127fa,
        32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92,
        32'hffeff47d, 32'h85845dd1, 32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};
    localparam int ST [16] = '{7, 12, 17, 22, 5, 9, 14, 20, 4, 11, 16, 23, 6, 10, 15, 21};

    typedef struct packed {
        logic [4:0]  st;
        logic        en;
        logic [31:0] tgt;
        int          dt;   // cycles since previous status change, -1 = don't care
    } exp_t;

    logic         CLK = 1'b0;
    logic         CPU_RESETN = 1'b1;
    logic         en_sw = 1'b0, en_sw_top = 1'b0;
    logic [127:0] tsel = 128'h0, tsel_top = 128'h0;
    logic [31:0]  target, target_top;
    logic         s_p, s_r, s_w, s_f, s_d, enabled;
    logic         t_p, t_r, t_w, t_f, t_d, enabled_top;

    int n_checks = 0;
    int n_fail   = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [127:0] h1, h3;

    always #5 CLK = ~CLK;

    driver dut (
        .CLK(CLK), .CPU_RESETN(CPU_RESETN), .enable_switch(en_sw), .target_selected(tsel),
        .target(target), .status_paused(s_p), .status_running(s_r), .status_warming(s_w),
        .status_found(s_f), .status_done(s_d), .enabled(enabled));

    driver #(.START_CANDIDATE(32'hFFFF_FFFE)) dut_top (
        .CLK(CLK), .CPU_RESETN(CPU_RESETN), .enable_switch(en_sw_top),
        .target_selected(tsel_top), .target(target_top), .status_paused(t_p),
        .status_running(t_r), .status_warming(t_w), .status_found(t_f),
        .status_done(t_d), .enabled(enabled_top));

    function automatic logic [31:0] bsw(input logic [31:0] v);
        return {v[7:0], v[15:8], v[23:16], v[31:24]};
    endfunction

    // Golden MD5 of the 8-character lowercase hex rendering of v.
    function automatic logic [127:0] md5_hex8(input logic [31:0] v);
        logic [7:0]  msg [64];
        logic [31:0] w [16];
        logic [31:0] a, b, c, d, f, x, tmp;
        int g, s;
        logic [3:0] nib;
        for (int j = 0; j < 64; j++) msg[j] = 8'h00;
        for (int j = 0; j < 8; j++) begin
            nib = 4'((v >> (28 - 4 * j)) & 32'hf);
            msg[j] = (nib < 10) ? 8'(48 + nib) : 8'(87 + nib);
        end
        msg[8]  = 8'h80;
        msg[56] = 8'd64;
        for (int j = 0; j < 16; j++)
            w[j] = {msg[4*j+3], msg[4*j+2], msg[4*j+1], msg[4*j]};
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
            s   = ST[(i / 16) * 4 + (i % 4)];
            x   = a + f + KT[i] + w[g];
            tmp = d; d = c; c = b;
            b   = b + ((x << s) | (x >> (32 - s)));
            a   = tmp;
        end
        return {bsw(a + 32'h67452301), bsw(b + 32'hefcdab89),
                bsw(c + 32'h98badcfe), bsw(d + 32'h10325476)};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic observe(input int ch, input logic [4:0] st, input logic en,
                           input logic [31:0] t, input int dt);
        exp_t e;
        if ((ch == 0 && q0.size() == 0) || (ch == 1 && q1.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_event ch%0d: got status %b target %h", ch, st, t);
        end else begin
            e = (ch == 0) ? q0.pop_front() : q1.pop_front();
            check($sformatf("ch%0d_status", ch), {123'b0, st}, {123'b0, e.st});
            check($sformatf("ch%0d_enabled", ch), {127'b0, en}, {127'b0, e.en});
            check($sformatf("ch%0d_target", ch), {96'b0, t}, {96'b0, e.tgt});
            if (e.dt >= 0)
                check($sformatf("ch%0d_cycles", ch), 128'(dt), 128'(e.dt));
        end
    endtask

    // Monitor: status vectors are compared against the queues on every change.
    logic [4:0] st0, st1;
    logic [4:0] prev0 = S_PAUSED, prev1 = S_PAUSED;
    int cyc = 0, last0 = 0, last1 = 0;
    assign st0 = {s_p, s_w, s_r, s_f, s_d};
    assign st1 = {t_p, t_w, t_r, t_f, t_d};

    always @(negedge CLK) begin
        cyc++;
        check("onehot_main", {127'b0, $onehot(st0)}, 128'd1);
        check("onehot_top",  {127'b0, $onehot(st1)}, 128'd1);
        if (st0 != prev0) begin
            observe(0, st0, enabled, target, cyc - last0);
            prev0 = st0;
            last0 = cyc;
        end
        if (st1 != prev1) begin
            observe(1, st1, enabled_top, target_top, cyc - last1);
            prev1 = st1;
            last1 = cyc;
        end
    end

    task automatic push0(input logic [4:0] st, input logic en, input logic [31:0] t, input int dt);
        q0.push_back('{st: st, en: en, tgt: t, dt: dt});
    endtask

    task automatic push1(input logic [4:0] st, input logic en, input logic [31:0] t, input int dt);
        q1.push_back('{st: st, en: en, tgt: t, dt: dt});
    endtask

    task automatic drain(input string name, input int bound);
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < bound) begin
            @(negedge CLK);
            n++;
        end
        n_checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_fail++;
            $display("FAIL timeout_%s: %0d events still pending, required 0",
                     name, q0.size() + q1.size());
            q0.delete();
            q1.delete();
        end
    endtask

    task automatic disable_main(input logic [31:0] hold_t);
        push0(S_PAUSED, 1'b0, hold_t, -1);
        en_sw = 1'b0;
        drain("disable", 20);
        repeat (3) @(negedge CLK);
    endtask

    initial begin
        h1 = md5_hex8(32'd1);
        h3 = md5_hex8(32'd3);
        check("golden_md5_00000000", md5_hex8(32'd0), H0);

        repeat (3) @(negedge CLK);
        check("reset_status", {123'b0, st0}, {123'b0, S_PAUSED});
        check("reset_target", {96'b0, target}, 128'd0);
        check("reset_enabled", {127'b0, enabled}, 128'd0);
        CPU_RESETN = 1'b0;
        repeat (2) @(negedge CLK);

        // Immediate match on candidate 0.
        tsel = H0;
        push0(S_WARMING, 1'b1, 32'd0, -1);
        push0(S_FOUND,   1'b1, 32'd0, 66);
        en_sw = 1'b1;
        drain("match0", 200);
        repeat (10) @(negedge CLK);
        check("found_hold", {127'b0, s_f}, 128'd1);
        disable_main(32'd0);

        // Match on candidate 3.
        tsel = h3;
        push0(S_WARMING, 1'b1, 32'd0, -1);
        push0(S_RUNNING, 1'b1, 32'd1, 66);
        push0(S_FOUND,   1'b1, 32'd3, 198);
        en_sw = 1'b1;
        drain("match3", 400);
        disable_main(32'd3);

        // Abort during candidate 2, retarget, restart from 0.
        tsel = h3;
        push0(S_WARMING, 1'b1, 32'd0, -1);
        push0(S_RUNNING, 1'b1, 32'd1, 66);
        en_sw = 1'b1;
        drain("abort_start", 200);
        repeat (86) @(negedge CLK);
        check("mid_candidate", {96'b0, target}, 128'd2);
        tsel = h1;
        disable_main(32'd2);
        push0(S_WARMING, 1'b1, 32'd0, -1);
        push0(S_RUNNING, 1'b1, 32'd1, 66);
        push0(S_FOUND,   1'b1, 32'd1, 66);
        en_sw = 1'b1;
        drain("restart", 300);
        disable_main(32'd1);

        // Target change mid-search is ignored.
        tsel = h1;
        push0(S_WARMING, 1'b1, 32'd0, -1);
        push0(S_RUNNING, 1'b1, 32'd1, 66);
        push0(S_FOUND,   1'b1, 32'd1, 66);
        en_sw = 1'b1;
        repeat (80) @(negedge CLK);
        tsel = h3;
        drain("latched_target", 300);
        disable_main(32'd1);

        // Asynchronous reset while running; switch still high at release.
        tsel = h3;
        push0(S_WARMING, 1'b1, 32'd0, -1);
        push0(S_RUNNING, 1'b1, 32'd1, 66);
        en_sw = 1'b1;
        drain("pre_reset", 200);
        repeat (10) @(negedge CLK);
        push0(S_PAUSED, 1'b0, 32'd0, -1);
        @(posedge CLK);
        #2 CPU_RESETN = 1'b1;
        #1;
        check("async_rst_paused", {127'b0, s_p}, 128'd1);
        check("async_rst_running", {127'b0, s_r}, 128'd0);
        check("async_rst_target", {96'b0, target}, 128'd0);
        check("async_rst_enabled", {127'b0, enabled}, 128'd0);
        tsel = H0;
        repeat (3) @(negedge CLK);
        push0(S_WARMING, 1'b1, 32'd0, -1);
        push0(S_FOUND,   1'b1, 32'd0, 66);
        CPU_RESETN = 1'b0;
        drain("post_reset", 200);
        disable_main(32'd0);

        // Top of the candidate space: no wrap, DONE held until enable falls.
        tsel_top = 128'h0;
        push1(S_WARMING, 1'b1, 32'hFFFF_FFFE, -1);
        push1(S_RUNNING, 1'b1, 32'hFFFF_FFFF, 66);
        push1(S_DONE,    1'b1, 32'hFFFF_FFFF, 66);
        en_sw_top = 1'b1;
        drain("exhaust", 300);
        repeat (30) @(negedge CLK);
        check("done_hold", {127'b0, t_d}, 128'd1);
        check("done_target", {96'b0, target_top}, {96'b0, 32'hFFFF_FFFF});
        push1(S_PAUSED, 1'b0, 32'hFFFF_FFFF, -1);
        en_sw_top = 1'b0;
        drain("exhaust_disable", 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/driver.md
DRIVER -- requirements
Module: driver

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-high reset named as the codebase does: CLK and CPU_RESETN.
REQ-002 The block SHALL expose these ports:
- CLK  input  1  rising-edge system clock.
- CPU_RESETN  input  1  asynchronous active-high reset; 1 = reset.
- enable_switch  input  1  asynchronous search-enable switch.
- target_selected  input  128  MD5 digest to search for; [127:120] = first digest byte in hex-string order.
- target  output  32  current candidate; after a match, the matching candidate.
- status_paused  output  1  search disabled.
- status_running  output  1  searching, at least one candidate already compared.
- status_warming  output  1  searching, first candidate not yet compared.
- status_found  output  1  match found.
- status_done  output  1  space exhausted, no match.
- enabled  output  1  synchronized enable_switch.

Function
REQ-003 enable_switch SHALL pass through a 2-flop synchronizer; enabled SHALL be the synchronizer output.
REQ-004 State machine SHALL have states PAUSED, WARMING, RUNNING, FOUND and DONE, with exactly one status_* output high, one-hot per state.
REQ-005 PAUSED -> WARMING on a rising edge of enabled; in the same cycle, target_selected SHALL be latched internally, the candidate SHALL be set to 0, and hashing SHALL start.
REQ-006 Any state -> PAUSED whenever enabled is 0; progress SHALL be discarded, so every re-enable restarts at candidate 0.
REQ-007 The candidate message SHALL be the 8 ASCII lowercase hex digits of the 32-bit candidate, most significant digit first (candidate 0x200 -> "00000200").
REQ-008 The message SHALL be padded to one 512-bit MD5 block: bytes 0-7 text, byte 8 = 0x80, bytes 9-55 = 0, bytes 56-63 = 64-bit little-endian bit length 64.
REQ-009 Hashing SHALL be iterative and standard RFC 1321 MD5 (IV, 64 K constants, shift table, F/G/H/I functions, little-endian words), one round per cycle.
REQ-010 Each candidate SHALL take exactly 66 cycles: 1 load cycle (A-D = IV), 64 round cycles, and 1 final cycle that adds the IV and compares the result.
REQ-011 The digest SHALL be compared as bytes A0..A3, B0..B3, C0..C3, D0..D3 against latched target [127:0], most significant first.
REQ-012 WARMING -> RUNNING after the first compare if there is no match.
REQ-013 On a match, from WARMING or RUNNING, the next state SHALL be FOUND; target SHALL hold the matching candidate until the state leaves FOUND.
REQ-014 No match with candidate 0xFFFFFFFF SHALL give DONE with target = 0xFFFFFFFF; the candidate counter SHALL never wrap.
REQ-015 No match otherwise SHALL increment the candidate by 1, and its load cycle SHALL immediately follow.
REQ-016 FOUND and DONE SHALL be held until enabled falls.
REQ-017 Changes to target_selected after the latch SHALL NOT affect the running search.
REQ-018 target SHALL equal the candidate being hashed during WARMING and RUNNING, and SHALL hold its last value in PAUSED.
REQ-019 If the enabled rise and fall are both pending at a state decision, enabled low SHALL win.

Reset
REQ-020 Reset asserted SHALL force, asynchronously:
- state PAUSED, status_paused = 1, other status outputs = 0
- target = 0, enabled = 0, synchronizer flops = 0
- internal hash registers = 0, latched target = 0
REQ-021 After reset release, a search SHALL start only on a new 0->1 transition of synchronized enabled; an enable_switch already high at release counts as a rising edge.
REQ-022 Reset mid-search SHALL abort immediately with no partial status retained.

Verification
REQ-023 Reset, then enable_switch=1, target_selected=0xdd4b21e9ef71e1291183a46b913ae6f2 (MD5 "00000000") -> status_warming for 66 cycles, then status_found=1, target=0x00000000.
REQ-024 target_selected = golden-model MD5 of "00000003" -> status_running after candidate 0, status_found after 4x66 cycles from start, target=0x00000003.
REQ-025 Search for the MD5 of "00000003"; drop enable during candidate 2, change target_selected to MD5 "00000001", re-enable -> restart at 0, status_found with target=0x00000001.
REQ-026 Change target_selected mid-search without dropping enable -> search continues against the originally latched digest.
REQ-027 Assert CPU_RESETN=1 while RUNNING -> immediately status_paused=1, target=0, enabled=0.
REQ-028 Force the candidate to 0xFFFFFFFE with an unmatched target -> after two compares status_done=1, target=0xFFFFFFFF, held until enable falls.
